// File: rtl/ssd_scan_ctrl.sv
// ssd_scan_ctrl: time-multiplexed seven-segment controller for common-anode
// displays. Holds a small per-digit register file (hex value, decimal point,
// blank flag), scans the digits one slot at a time and dims them with a PWM
// window taken from the top bits of the slot counter.
module ssd_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int SEL_W        = 2,
  parameter int REFRESH_LOG2 = 17,
  parameter int BRIGHT_W     = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr,
  input  logic [SEL_W-1:0]      sel,
  input  logic [3:0]            num,
  input  logic                  dp_in,
  input  logic                  blank_in,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic [NUM_DIGITS-1:0] anode,
  output logic [6:0]            cathode,
  output logic                  dp,
  output logic [SEL_W-1:0]      scan_idx
);

  localparam logic [SEL_W-1:0]      LAST_IDX = SEL_W'(NUM_DIGITS - 1);
  localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

  logic [REFRESH_LOG2-1:0] cnt;
  logic                    slot_end;
  logic [BRIGHT_W-1:0]     phase;

  logic [3:0] val_q   [NUM_DIGITS];
  logic       dp_q    [NUM_DIGITS];
  logic       blank_q [NUM_DIGITS];

  logic [3:0] cur_val;
  logic       cur_dp;
  logic       cur_blank;
  logic       lit;
  logic [6:0] seg;
  logic       wr_ok;

  assign slot_end = &cnt;
  assign phase    = cnt[REFRESH_LOG2-1 -: BRIGHT_W];
  assign wr_ok    = wr && (int'(sel) < NUM_DIGITS);

  // Free-running slot counter; the digit index steps once per counter wrap.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values, independent of always-block ordering.
    if (reset) begin
      cnt      <= '0;
      scan_idx <= '0;
    end else begin
      cnt <= cnt + 1'b1;
      if (slot_end) begin
        scan_idx <= (scan_idx == LAST_IDX) ? '0 : scan_idx + 1'b1;
      end
    end
  end

  // Register file: one entry per digit, written through the sel/wr port.
  always_ff @(posedge clk) begin
    // NOTE: this storage is a handful of flops rather than a RAM macro, so it
    // is reset explicitly; every digit must come up blank.
    if (reset) begin
      for (int i = 0; i < NUM_DIGITS; i++) begin
        val_q[i]   <= 4'h0;
        dp_q[i]    <= 1'b0;
        blank_q[i] <= 1'b1;
      end
    end else if (wr_ok) begin
      val_q[sel]   <= num;
      dp_q[sel]    <= dp_in;
      blank_q[sel] <= blank_in;
    end
  end

  assign cur_val   = val_q[scan_idx];
  assign cur_dp    = dp_q[scan_idx];
  assign cur_blank = blank_q[scan_idx];
  assign lit       = (phase <= brightness) && !cur_blank;

  // Hex to active-low {g,f,e,d,c,b,a} segment decode.
  always_comb begin
    // NOTE: the default assignment ahead of the case keeps this block free of
    // inferred latches even if an arm is ever removed.
    seg = 7'h7F;
    unique case (cur_val)
      4'h0: seg = 7'h40;
      4'h1: seg = 7'h79;
      4'h2: seg = 7'h24;
      4'h3: seg = 7'h30;
      4'h4: seg = 7'h19;
      4'h5: seg = 7'h12;
      4'h6: seg = 7'h02;
      4'h7: seg = 7'h78;
      4'h8: seg = 7'h00;
      4'h9: seg = 7'h10;
      4'hA: seg = 7'h08;
      4'hB: seg = 7'h03;
      4'hC: seg = 7'h46;
      4'hD: seg = 7'h21;
      4'hE: seg = 7'h06;
      4'hF: seg = 7'h0E;
      default: seg = 7'h7F;
    endcase
  end

  // Registered pin drive: anode, segments and dp are loaded together from the
  // same digit, so a digit change can never pair old segments with a new anode.
  always_ff @(posedge clk) begin
    if (reset) begin
      anode   <= '1;
      cathode <= 7'h7F;
      dp      <= 1'b1;
    end else if (lit) begin
      anode   <= ~(ONE_HOT0 << scan_idx);
      cathode <= seg;
      dp      <= ~cur_dp;
    end else begin
      anode   <= '1;
      cathode <= 7'h7F;
      dp      <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl. Two instances (4 digits and 3 digits,
// 16-cycle slots, 2-bit brightness) share the same stimulus; a time-based
// model predicts every output cycle, and literal checks pin the model.
module tb_ssd_scan_ctrl;

  localparam int R    = 4;
  localparam int B    = 2;
  localparam int SLOT = 1 << R;

  logic       clk = 1'b0;
  logic       reset;
  logic       wr;
  logic [1:0] sel;
  logic [3:0] num;
  logic       dp_in;
  logic       blank_in;
  logic [1:0] brightness;

  logic [3:0] anode4;
  logic [6:0] cathode4;
  logic       dp4;
  logic [1:0] idx4;
  logic [2:0] anode3;
  logic [6:0] cathode3;
  logic       dp3;
  logic [1:0] idx3;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ssd_scan_ctrl #(.NUM_DIGITS(4), .SEL_W(2), .REFRESH_LOG2(R), .BRIGHT_W(B)) u4 (
    .clk(clk), .reset(reset), .wr(wr), .sel(sel), .num(num), .dp_in(dp_in),
    .blank_in(blank_in), .brightness(brightness), .anode(anode4),
    .cathode(cathode4), .dp(dp4), .scan_idx(idx4));

  ssd_scan_ctrl #(.NUM_DIGITS(3), .SEL_W(2), .REFRESH_LOG2(R), .BRIGHT_W(B)) u3 (
    .clk(clk), .reset(reset), .wr(wr), .sel(sel), .num(num), .dp_in(dp_in),
    .blank_in(blank_in), .brightness(brightness), .anode(anode3),
    .cathode(cathode3), .dp(dp3), .scan_idx(idx3));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Time-based view: after t edges out of reset the slot number is t/SLOT,
  // the digit is that slot mod N and the PWM phase is the position inside
  // the slot scaled down to B bits. Outputs lag that state by one edge.
  logic [6:0] seg_tab [16];
  initial begin
    seg_tab = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  end

  longint     t;
  logic       armed = 1'b0;
  logic [3:0] mval [2][4];
  logic       mdp  [2][4];
  logic       mblk [2][4];
  logic [3:0] e_an  [2];
  logic [6:0] e_cat [2];
  logic       e_dp  [2];
  int         e_idx [2];

  function automatic int nd_of(input int k);
    return (k == 0) ? 4 : 3;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      armed = 1'b1;
      t = 0;
      for (int k = 0; k < 2; k++) begin
        for (int i = 0; i < 4; i++) begin
          mval[k][i] = 4'h0;
          mdp[k][i]  = 1'b0;
          mblk[k][i] = 1'b1;
        end
        e_an[k]  = 4'hF;
        e_cat[k] = 7'h7F;
        e_dp[k]  = 1'b1;
        e_idx[k] = 0;
      end
    end else begin
      int phase;
      phase = int'((t % SLOT) / (SLOT >> B));
      for (int k = 0; k < 2; k++) begin
        int d;
        d = int'((t / SLOT) % nd_of(k));
        if (phase <= int'(brightness) && !mblk[k][d]) begin
          e_an[k]  = ~(4'b0001 << d);
          e_cat[k] = seg_tab[mval[k][d]];
          e_dp[k]  = ~mdp[k][d];
        end else begin
          e_an[k]  = 4'hF;
          e_cat[k] = 7'h7F;
          e_dp[k]  = 1'b1;
        end
        if (wr && int'(sel) < nd_of(k)) begin
          mval[k][sel] = num;
          mdp[k][sel]  = dp_in;
          mblk[k][sel] = blank_in;
        end
      end
      t = t + 1;
      for (int k = 0; k < 2; k++) e_idx[k] = int'((t / SLOT) % nd_of(k));
    end
  end

  // Every-cycle comparison of both instances against the model.
  always @(negedge clk) begin
    if (armed) begin
      check("anode4",   anode4,   e_an[0]);
      check("cathode4", cathode4, e_cat[0]);
      check("dp4",      dp4,      e_dp[0]);
      check("scan_idx4", idx4,    e_idx[0]);
      check("anode3",   anode3,   e_an[1][2:0]);
      check("cathode3", cathode3, e_cat[1]);
      check("dp3",      dp3,      e_dp[1]);
      check("scan_idx3", idx3,    e_idx[1]);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write(input logic [1:0] s, input logic [3:0] v, input logic d, input logic b);
    wr = 1'b1; sel = s; num = v; dp_in = d; blank_in = b;
    tick(1);
    wr = 1'b0;
  endtask

  // Bounded wait for an instance's scan_idx to reach a value.
  task automatic wait_idx(input int k, input int want);
    int n;
    n = 0;
    while (((k == 0) ? int'(idx4) : int'(idx3)) != want && n < 200) begin
      tick(1);
      n++;
    end
    check("wait_scan_idx", (k == 0) ? idx4 : idx3, want);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int c_a;
    int c_b;
    reset = 1'b1; wr = 1'b0; sel = 2'd0; num = 4'h0; dp_in = 1'b0;
    blank_in = 1'b0; brightness = 2'd3;

    // 1: reset state, then an undisturbed blank sweep
    tick(2);
    check("rst_anode4", anode4, 4'hF);
    check("rst_cathode4", cathode4, 7'h7F);
    check("rst_dp4", dp4, 1'b1);
    check("rst_idx4", idx4, 2'd0);
    reset = 1'b0;
    tick(100);
    check("dark_anode4", anode4, 4'hF);
    check("dark_idx4", idx4, 2'd2);
    check("dark_idx3", idx3, 2'd0);

    // 2: four digits 4,5,6,7 at full brightness, fixed timing from reset
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    write(2'd0, 4'h4, 1'b0, 1'b0);
    write(2'd1, 4'h5, 1'b0, 1'b0);
    write(2'd2, 4'h6, 1'b0, 1'b0);
    write(2'd3, 4'h7, 1'b0, 1'b0);
    tick(1);
    check("s2_an_d0", anode4, 4'b1110);
    check("s2_cat_d0", cathode4, 7'h19);
    tick(15);
    check("s2_an_d1", anode4, 4'b1101);
    check("s2_cat_d1", cathode4, 7'h12);
    tick(16);
    check("s2_an_d2", anode4, 4'b1011);
    check("s2_cat_d2", cathode4, 7'h02);
    tick(16);
    check("s2_an_d3", anode4, 4'b0111);
    check("s2_cat_d3", cathode4, 7'h78);
    check("s2_an3_d0", anode3, 3'b110);
    check("s2_idx3", idx3, 2'd0);
    tick(16);
    check("s2_an_wrap", anode4, 4'b1110);
    check("s2_cat_wrap", cathode4, 7'h19);

    // 3: dimmest level lights a quarter of digit 0's slot
    brightness = 2'd0;
    write(2'd0, 4'hA, 1'b0, 1'b0);
    tick(2);
    c_a = 0; c_b = 0;
    for (int i = 0; i < 64; i++) begin
      if (anode4 == 4'b1110 && cathode4 == 7'h08) c_a++;
      if (anode4 == 4'hF) c_b++;
      tick(1);
    end
    check("s3_lit_cycles", c_a, 4);
    check("s3_dark_cycles", c_b, 48);

    // 4: decimal point on digit 2, then blank it
    brightness = 2'd3;
    write(2'd2, 4'hF, 1'b1, 1'b0);
    tick(1);
    c_a = 0;
    for (int i = 0; i < 64; i++) begin
      if (anode4 == 4'b1011 && cathode4 == 7'h0E && dp4 == 1'b0) c_a++;
      tick(1);
    end
    check("s4_dp_digit2", c_a, 16);
    write(2'd2, 4'hF, 1'b1, 1'b1);
    tick(1);
    c_a = 0; c_b = 0;
    for (int i = 0; i < 64; i++) begin
      if (anode4 == 4'b1011) c_a++;
      if (anode4 == 4'b1110 && cathode4 == 7'h08) c_b++;
      tick(1);
    end
    check("s4_blank_digit2", c_a, 0);
    check("s4_digit0_kept", c_b, 16);

    // 5: out-of-range write is ignored by the 3-digit instance
    write(2'd3, 4'h8, 1'b1, 1'b0);
    tick(1);
    c_a = 0; c_b = 0;
    for (int i = 0; i < 48; i++) begin
      if (anode3 == 3'b011) c_a++;
      if (anode3 == 3'b110 && cathode3 == 7'h08) c_b++;
      tick(1);
    end
    check("s5_digit2_still_blank", c_a, 0);
    check("s5_digit0_intact", c_b, 16);
    wait_idx(1, 0);
    wait_idx(1, 1);
    write(2'd1, 4'h2, 1'b0, 1'b0);
    check("s5_cat_before", cathode3, 7'h12);
    tick(1);
    check("s5_cat_after", cathode3, 7'h24);
    check("s5_an_after", anode3, 3'b101);

    // 6: reset in the middle of digit 2's slot
    wait_idx(0, 2);
    tick(5);
    reset = 1'b1;
    tick(1);
    check("s6_anode4", anode4, 4'hF);
    check("s6_cathode4", cathode4, 7'h7F);
    check("s6_idx4", idx4, 2'd0);
    check("s6_idx3", idx3, 2'd0);
    reset = 1'b0;
    c_a = 0;
    for (int i = 0; i < 64; i++) begin
      if (anode4 != 4'hF || anode3 != 3'b111) c_a++;
      tick(1);
    end
    check("s6_dark_sweep", c_a, 0);

    // Randomized traffic, checked cycle by cycle against the model
    for (int i = 0; i < 2000; i++) begin
      reset      = ($urandom_range(0, 199) == 0);
      wr         = ($urandom_range(0, 3) == 0);
      sel        = 2'($urandom_range(0, 3));
      num        = 4'($urandom_range(0, 15));
      dp_in      = 1'($urandom_range(0, 1));
      blank_in   = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 31) == 0) brightness = 2'($urandom_range(0, 3));
      tick(1);
    end
    reset = 1'b0; wr = 1'b0;
    tick(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
Name: ssd_scan_ctrl

Overview:
- Parametrised multiplexed seven-segment display controller. Successor to the fixed 4-digit, 3-bit-value display top.
- Holds a per-digit register file of hex value, decimal point and blank flag, written through a sel/wr port.
- Scans the digits time-multiplexed and adds PWM brightness control.
- Sits between control logic or a CPU register interface and the board's common-anode display pins.

Parameters:
- NUM_DIGITS, 4, number of digits driven (2..16).
- SEL_W, 2, width of sel and scan_idx; must satisfy 2^SEL_W >= NUM_DIGITS.
- REFRESH_LOG2, 17, each digit slot lasts 2^REFRESH_LOG2 clk cycles.
- BRIGHT_W, 3, width of brightness; must be < REFRESH_LOG2.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset.
- wr  in  1  write strobe; a write occurs on a clk edge with wr=1.
- sel  in  SEL_W  digit index written.
- num  in  4  hex value written (0x0..0xF).
- dp_in  in  1  decimal-point flag written (1 = lit).
- blank_in  in  1  blank flag written (1 = digit dark).
- brightness  in  BRIGHT_W  PWM level; 0 = dimmest, all-ones = full on.
- anode  out  NUM_DIGITS  digit enables, active-low, one-hot-low.
- cathode  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low.
- scan_idx  out  SEL_W  index of the digit in the current slot.

Behaviour:
- Reset, synchronous: slot counter=0, scan_idx=0.
  - All register-file entries: value=0, dp=0, blank=1.
  - Outputs: anode=all ones, cathode=7'h7F, dp=1.
  - Reset overrides wr in the same cycle.
  - Reset mid-scan returns to digit 0 on the next edge with display dark.
- Write: on a clk edge with wr=1 and sel<NUM_DIGITS, entry[sel]={blank_in,dp_in,num} is updated.
  - sel>=NUM_DIGITS is ignored; no entry changes.
- Slot counter: REFRESH_LOG2 bits, free-running, wraps 2^REFRESH_LOG2-1 -> 0.
  - On wrap, scan_idx advances by 1.
  - scan_idx wraps NUM_DIGITS-1 -> 0; values >= NUM_DIGITS are never reached.
- PWM: phase = top BRIGHT_W bits of the slot counter.
  - Digit is on when phase <= brightness.
  - Full brightness lights the whole slot; brightness=0 lights 1/2^BRIGHT_W of the slot.
  - brightness is sampled every cycle; a change takes effect immediately, with no slot resync.
- Outputs are registered, one cycle behind the counter, scan_idx and register-file state:
  - on: anode = ~(1<<scan_idx), cathode = decode(value), dp = ~dp_flag.
  - off, or entry blank=1: anode, cathode and dp all ones.
  - A write to the currently displayed digit appears on cathode one edge after the write edge.
- Decode table (active-low {g..a}):
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- At most one anode bit is low in any cycle.
- On the registered scan_idx change there is no cycle with two anodes low, and no cycle where the old digit's segments drive the new anode.

Test Plan:
Scenarios 2–5 use REFRESH_LOG2=4, BRIGHT_W=2.
1. Hold reset 2 cycles, then release with no writes -> anode=1111, cathode=7F, dp=1 for 100 cycles; scan_idx counts 0,1,2,3,0 every 16 cycles.
2. Brightness=3; write 4,5,6,7 to sel 0..3 with blank=0, dp=0 -> per 16-cycle slot, in order:
   - anode=1110 / cathode=19
   - anode=1101 / cathode=12
   - anode=1011 / cathode=02
   - anode=0111 / cathode=78
   - then wraps back to digit 0.
3. Brightness=0, digit 0 holding 0xA -> anode=1110 and cathode=08 for exactly 4 of 16 cycles; all ones for the other 12 cycles.
4. Write digit 2 with num=0xF, dp=1, then rewrite it with blank=1 -> first dp=0 and cathode=0E during slot 2; after the rewrite, slot 2 shows all ones and the other digits are unaffected.
5. NUM_DIGITS=3, SEL_W=2, write sel=3 -> no entry changes. scan_idx sequence 0,1,2,0 and anode uses 3 bits. Write during slot 1 to sel=1 changes cathode the next edge.
6. Reset asserted mid-slot of digit 2 -> next edge: anode=all ones, scan_idx=0, counter=0, all entries blank. A display sweep after reset shows nothing until new writes.
